snoop_responder: RTL and testbench
==================================

SNOOP_RESPONDER -- requirements
Module: snoop_responder

Interface
REQ-001 SHALL have parameter I_SIZE, default 32, address width in bits.
REQ-002 SHALL have parameter C_SIZE, default 24, log2 of capacity in bytes.
REQ-003 SHALL have parameter D_SIZE, default 6, log2 of line size in bytes.
REQ-004 SHALL have parameter A_SIZE, default 8, ways; IDX_W = C_SIZE - log2(A_SIZE) - D_SIZE (15) and TAG_W = I_SIZE - IDX_W - D_SIZE (11).
REQ-005 SHALL have ports as follows; one clock, reset asynchronous active-high:
 clk  in  1  clock
 rst  in  1  async reset, active-high
 snoop_valid  in  1  snooped bus operation present
 snoop_op  in  3  bus op: READ=1, WRITE=2, INVALIDATE=3, RWIM=4
 snoop_addr  in  I_SIZE  snooped address
 snoop_ready  out  1  responder idle, can accept
 lookup_req  out  1  tag lookup request to cache
 lookup_index  out  IDX_W  set index
 lookup_tag  out  TAG_W  tag
 lookup_ack  in  1  lookup result valid
 lookup_hit  in  1  tag hit
 lookup_way  in  log2(A_SIZE)  hit way
 lookup_mesi  in  2  line state: I=0, S=1, E=2, M=3
 snoop_result  out  2  NOHIT=0, HIT=1, HITM=2
 snoop_result_valid  out  1  one-cycle result strobe
 l2_l1_msg  out  3  GETLINE=1, SENDLINE=2, INVALIDATELINE=3, EVICTLINE=4
 l2_l1_valid  out  1  message valid, held until ack
 l2_l1_ack  in  1  L1 accepted message
 wb_valid  out  1  writeback bus op valid, held until ack
 wb_addr  out  I_SIZE  line-aligned writeback address (byte bits zero)
 wb_ack  in  1  bus accepted writeback
 upd_valid  out  1  one-cycle MESI update strobe
 upd_index / upd_way / upd_mesi  out  IDX_W / log2(A_SIZE) / 2  state write-back to tag array

Function
REQ-006 SHALL run FSM IDLE -> LOOKUP -> RESULT -> [GET_L1] -> [WRITEBACK] -> [INV_L1] -> UPDATE -> IDLE; bracketed states skipped when not required.
REQ-007 snoop_ready SHALL be 1 only in IDLE; transaction accepted when snoop_valid && snoop_ready; op/address registered.
REQ-008 LOOKUP: lookup_req held high with registered index/tag until lookup_ack; ack in first LOOKUP cycle is legal.
REQ-009 Miss or lookup_mesi=I SHALL be treated as state I.
REQ-010 RESULT: snoop_result_valid pulses one cycle; READ: M->HITM, E/S->HIT, I->NOHIT; RWIM: M->HITM, E/S->HIT, I->NOHIT; WRITE and INVALIDATE: NOHIT.
REQ-011 READ on M: GETLINE, WRITEBACK, next S. READ on E: next S. READ on S: no update.
REQ-012 RWIM on M: GETLINE, WRITEBACK, INVALIDATELINE, next I. RWIM on E/S: INVALIDATELINE, next I.
REQ-013 INVALIDATE on S: INVALIDATELINE, next I; INVALIDATE on E/M (protocol-illegal) and WRITE on any state: no message, no update.
REQ-014 Each message/writeback handshake SHALL complete when valid && ack; next state entered the following cycle; valid never dropped before ack.
REQ-015 UPDATE: upd_valid pulses one cycle with registered index, lookup_way, next state; skipped when state unchanged.
REQ-016 Minimum latency accept->snoop_result_valid: 2 cycles (ack in first LOOKUP cycle).

Reset
REQ-017 rst SHALL asynchronously force IDLE and all outputs 0 except snoop_ready=1; any in-flight transaction aborted with no update issued.

Configuration
REQ-018 With SNOOP_STATS_EN defined, SHALL add outputs snoop_cnt and hitm_cnt (32 bits, reset 0, increment on accept and on HITM result, wrap at 2^32); without it, ports and counters absent.

Structure
REQ-019 cache_pkg SHALL hold bus_op_t, snoop_result_t, l2_l1_msg_t, mesi_t enums and the default geometry constants.
REQ-020 Address split SHALL reuse the existing address_parse sub-module; no other sub-modules.

Verification
REQ-021 READ, addr 0x0001_2345, hit M way 5 -> HITM, GETLINE, wb_addr 0x0001_2340, upd_mesi S way 5.
REQ-022 RWIM, hit S -> HIT, INVALIDATELINE, upd_mesi I; no writeback.
REQ-023 READ, miss -> NOHIT, no message, no upd_valid, back in IDLE 3 cycles after accept.
REQ-024 INVALIDATE on E -> NOHIT, no message, no update; WRITE on M -> NOHIT, no update.
REQ-025 l2_l1_ack withheld 10 cycles during GETLINE -> l2_l1_valid stable; rst asserted mid-WRITEBACK -> immediate IDLE, wb_valid 0, no upd_valid.
REQ-026 With SNOOP_STATS_EN: 4 snoops, 1 HITM -> snoop_cnt 4, hitm_cnt 1.

Source files
------------

// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared types and default geometry for the L2 snoop responder:
//               bus operations, snoop results, L2->L1 messages, MESI states and
//               the op/state decision function used by the responder FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

  // Default cache geometry (32-bit address, 16 MiB, 64 B lines, 8 ways)
  localparam int DEF_I_SIZE = 32;
  localparam int DEF_C_SIZE = 24;
  localparam int DEF_D_SIZE = 6;
  localparam int DEF_A_SIZE = 8;

  typedef enum logic [2:0] {
    OP_NONE       = 3'd0,
    OP_READ       = 3'd1,
    OP_WRITE      = 3'd2,
    OP_INVALIDATE = 3'd3,
    OP_RWIM       = 3'd4
  } bus_op_t;

  typedef enum logic [1:0] {
    RES_NOHIT = 2'd0,
    RES_HIT   = 2'd1,
    RES_HITM  = 2'd2
  } snoop_result_t;

  typedef enum logic [2:0] {
    MSG_NONE           = 3'd0,
    MSG_GETLINE        = 3'd1,
    MSG_SENDLINE       = 3'd2,
    MSG_INVALIDATELINE = 3'd3,
    MSG_EVICTLINE      = 3'd4
  } l2_l1_msg_t;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_t;

  // Everything the responder must do for one snoop, decided once after lookup
  typedef struct packed {
    logic [1:0] result;
    logic       get_line;
    logic       write_back;
    logic       inv_line;
    logic       update;
    logic [1:0] next_mesi;
  } snoop_action_t;

  // Map (bus op, effective line state) to the response and follow-up actions.
  // A miss must already have been folded into MESI_I by the caller.
  function automatic snoop_action_t snoop_action(input logic [2:0] op,
                                                 input logic [1:0] st);
    snoop_action_t a;
    a           = '0;
    a.result    = RES_NOHIT;
    a.next_mesi = st;
    case (op)
      OP_READ: begin
        case (st)
          MESI_M: begin
            a.result     = RES_HITM;
            a.get_line   = 1'b1;
            a.write_back = 1'b1;
            a.next_mesi  = MESI_S;
          end
          MESI_E: begin
            a.result    = RES_HIT;
            a.next_mesi = MESI_S;
          end
          MESI_S:  a.result = RES_HIT;
          default: ;
        endcase
      end
      OP_RWIM: begin
        case (st)
          MESI_M: begin
            a.result     = RES_HITM;
            a.get_line   = 1'b1;
            a.write_back = 1'b1;
            a.inv_line   = 1'b1;
            a.next_mesi  = MESI_I;
          end
          MESI_E, MESI_S: begin
            a.result    = RES_HIT;
            a.inv_line  = 1'b1;
            a.next_mesi = MESI_I;
          end
          default: ;
        endcase
      end
      OP_INVALIDATE: begin
        // Invalidate of an E/M line cannot happen in a legal protocol; ignore it
        if (st == MESI_S) begin
          a.inv_line  = 1'b1;
          a.next_mesi = MESI_I;
        end
      end
      default: ;
    endcase
    a.update = (a.next_mesi != st);
    return a;
  endfunction

endpackage : cache_pkg
`default_nettype wire

// File: rtl/address_parse.sv
`default_nettype none
// ============================================================================
// Module      : address_parse
// Description : Splits a byte address into set index and tag, and produces
//               the line-aligned address (offset bits cleared).
// Revision    : 1.0 - initial release
// ============================================================================
module address_parse #(
  parameter int I_SIZE = 32,
  parameter int C_SIZE = 24,
  parameter int D_SIZE = 6,
  parameter int A_SIZE = 8
) (
  input  logic [I_SIZE-1:0]                        addr_i,
  output logic [C_SIZE-$clog2(A_SIZE)-D_SIZE-1:0]  index_o,
  output logic [I_SIZE-C_SIZE+$clog2(A_SIZE)-1:0]  tag_o,
  output logic [I_SIZE-1:0]                        line_addr_o
);

  localparam int IDX_W = C_SIZE - $clog2(A_SIZE) - D_SIZE;
  localparam int TAG_W = I_SIZE - IDX_W - D_SIZE;
  localparam logic [I_SIZE-1:0] OFFS_MASK = I_SIZE'((64'd1 << D_SIZE) - 64'd1);

  assign index_o     = addr_i[D_SIZE +: IDX_W];
  assign tag_o       = addr_i[D_SIZE+IDX_W +: TAG_W];
  assign line_addr_o = addr_i & ~OFFS_MASK;

endmodule : address_parse
`default_nettype wire

// File: rtl/snoop_responder.sv
`default_nettype none
// ============================================================================
// Module      : snoop_responder
// Description : L2 snoop responder. Accepts one snooped bus operation at a
//               time, looks the line up in the tag array, reports
//               NOHIT/HIT/HITM, pulls dirty data out of L1, writes it back,
//               invalidates L1 and finally updates the MESI state.
//               Optional build macro SNOOP_STATS_EN adds snoop_cnt/hitm_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module snoop_responder
  import cache_pkg::*;
#(
  parameter int I_SIZE = DEF_I_SIZE,
  parameter int C_SIZE = DEF_C_SIZE,
  parameter int D_SIZE = DEF_D_SIZE,
  parameter int A_SIZE = DEF_A_SIZE
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      snoop_valid,
  input  logic [2:0]                                snoop_op,
  input  logic [I_SIZE-1:0]                         snoop_addr,
  output logic                                      snoop_ready,
  output logic                                      lookup_req,
  output logic [C_SIZE-$clog2(A_SIZE)-D_SIZE-1:0]   lookup_index,
  output logic [I_SIZE-C_SIZE+$clog2(A_SIZE)-1:0]   lookup_tag,
  input  logic                                      lookup_ack,
  input  logic                                      lookup_hit,
  input  logic [$clog2(A_SIZE)-1:0]                 lookup_way,
  input  logic [1:0]                                lookup_mesi,
  output logic [1:0]                                snoop_result,
  output logic                                      snoop_result_valid,
  output logic [2:0]                                l2_l1_msg,
  output logic                                      l2_l1_valid,
  input  logic                                      l2_l1_ack,
  output logic                                      wb_valid,
  output logic [I_SIZE-1:0]                         wb_addr,
  input  logic                                      wb_ack,
  output logic                                      upd_valid,
  output logic [C_SIZE-$clog2(A_SIZE)-D_SIZE-1:0]   upd_index,
  output logic [$clog2(A_SIZE)-1:0]                 upd_way,
`ifdef SNOOP_STATS_EN
  output logic [31:0]                               snoop_cnt,
  output logic [31:0]                               hitm_cnt,
`endif
  output logic [1:0]                                upd_mesi
);

  localparam int IDX_W = C_SIZE - $clog2(A_SIZE) - D_SIZE;
  localparam int TAG_W = I_SIZE - IDX_W - D_SIZE;
  localparam int WAY_W = $clog2(A_SIZE);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOOKUP    = 3'd1;
  localparam logic [2:0] S_RESULT    = 3'd2;
  localparam logic [2:0] S_GET_L1    = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_INV_L1    = 3'd5;
  localparam logic [2:0] S_UPDATE    = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [2:0]        op_q;
  logic [IDX_W-1:0]  idx_q;
  logic [TAG_W-1:0]  tag_q;
  logic [I_SIZE-1:0] line_q;
  logic [WAY_W-1:0]  way_q;
  logic [1:0]        mesi_q;

  logic [IDX_W-1:0]  idx_w;
  logic [TAG_W-1:0]  tag_w;
  logic [I_SIZE-1:0] line_w;
  logic              accept_w;
  snoop_action_t     act_w;
  logic [2:0]        after_wb_w;
  logic [2:0]        after_get_w;

  address_parse #(
    .I_SIZE (I_SIZE),
    .C_SIZE (C_SIZE),
    .D_SIZE (D_SIZE),
    .A_SIZE (A_SIZE)
  ) u_address_parse (
    .addr_i      (snoop_addr),
    .index_o     (idx_w),
    .tag_o       (tag_w),
    .line_addr_o (line_w)
  );

  assign accept_w = snoop_valid && (state_q == S_IDLE);
  assign act_w    = snoop_action(op_q, mesi_q);

  // Successor chain of the optional phases: each phase hands off to the next
  // required one, and UPDATE is visited only when the line state changes.
  assign after_wb_w  = act_w.inv_line   ? S_INV_L1    :
                       act_w.update     ? S_UPDATE    : S_IDLE;
  assign after_get_w = act_w.write_back ? S_WRITEBACK : after_wb_w;

  // Next-state selection; handshake phases advance only on valid && ack
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (snoop_valid) state_d = S_LOOKUP;
      S_LOOKUP:    if (lookup_ack)  state_d = S_RESULT;
      S_RESULT:    state_d = act_w.get_line ? S_GET_L1 : after_get_w;
      S_GET_L1:    if (l2_l1_ack)   state_d = after_get_w;
      S_WRITEBACK: if (wb_ack)      state_d = after_wb_w;
      S_INV_L1:    if (l2_l1_ack)   state_d = act_w.update ? S_UPDATE : S_IDLE;
      S_UPDATE:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any in-flight snoop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Capture the snooped request on accept and the tag result on lookup ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      idx_q  <= '0;
      tag_q  <= '0;
      line_q <= '0;
      way_q  <= '0;
      mesi_q <= '0;
    end else begin
      if (accept_w) begin
        op_q   <= snoop_op;
        idx_q  <= idx_w;
        tag_q  <= tag_w;
        line_q <= line_w;
      end
      if ((state_q == S_LOOKUP) && lookup_ack) begin
        way_q  <= lookup_way;
        mesi_q <= lookup_hit ? lookup_mesi : MESI_I;
      end
    end
  end

  assign snoop_ready        = (state_q == S_IDLE);
  assign lookup_req         = (state_q == S_LOOKUP);
  assign lookup_index       = idx_q;
  assign lookup_tag         = tag_q;
  assign snoop_result_valid = (state_q == S_RESULT);
  assign snoop_result       = (state_q == S_RESULT) ? act_w.result : RES_NOHIT;
  assign l2_l1_valid        = (state_q == S_GET_L1) || (state_q == S_INV_L1);
  assign l2_l1_msg          = (state_q == S_GET_L1) ? MSG_GETLINE :
                              (state_q == S_INV_L1) ? MSG_INVALIDATELINE : MSG_NONE;
  assign wb_valid           = (state_q == S_WRITEBACK);
  assign wb_addr            = line_q;
  assign upd_valid          = (state_q == S_UPDATE);
  assign upd_index          = idx_q;
  assign upd_way            = way_q;
  assign upd_mesi           = act_w.next_mesi;

`ifdef SNOOP_STATS_EN
  logic [31:0] snoop_cnt_q;
  logic [31:0] hitm_cnt_q;

  // Free-running wrap-around counters of accepted snoops and HITM responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snoop_cnt_q <= '0;
      hitm_cnt_q  <= '0;
    end else begin
      if (accept_w) snoop_cnt_q <= snoop_cnt_q + 32'd1;
      if ((state_q == S_RESULT) && (act_w.result == RES_HITM))
        hitm_cnt_q <= hitm_cnt_q + 32'd1;
    end
  end

  assign snoop_cnt = snoop_cnt_q;
  assign hitm_cnt  = hitm_cnt_q;
`endif

endmodule : snoop_responder
`default_nettype wire

// File: tb/tb_snoop_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_snoop_responder
// Description : Self-checking bench for snoop_responder: directed vector
//               table, randomized snoops against a rule-level reference model,
//               L1 ack stall and reset-during-writeback sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snoop_responder;
  import cache_pkg::*;

  localparam int IDX_W = 15;
  localparam int TAG_W = 11;
  localparam int WAY_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              snoop_valid;
  logic [2:0]        snoop_op;
  logic [31:0]       snoop_addr;
  logic              snoop_ready;
  logic              lookup_req;
  logic [IDX_W-1:0]  lookup_index;
  logic [TAG_W-1:0]  lookup_tag;
  logic              lookup_ack;
  logic              lookup_hit;
  logic [WAY_W-1:0]  lookup_way;
  logic [1:0]        lookup_mesi;
  logic [1:0]        snoop_result;
  logic              snoop_result_valid;
  logic [2:0]        l2_l1_msg;
  logic              l2_l1_valid;
  logic              l2_l1_ack;
  logic              wb_valid;
  logic [31:0]       wb_addr;
  logic              wb_ack;
  logic              upd_valid;
  logic [IDX_W-1:0]  upd_index;
  logic [WAY_W-1:0]  upd_way;
  logic [1:0]        upd_mesi;
`ifdef SNOOP_STATS_EN
  logic [31:0]       snoop_cnt;
  logic [31:0]       hitm_cnt;
`endif

  always #5 clk = ~clk;

  snoop_responder dut (
    .clk                (clk),
    .rst                (rst),
    .snoop_valid        (snoop_valid),
    .snoop_op           (snoop_op),
    .snoop_addr         (snoop_addr),
    .snoop_ready        (snoop_ready),
    .lookup_req         (lookup_req),
    .lookup_index       (lookup_index),
    .lookup_tag         (lookup_tag),
    .lookup_ack         (lookup_ack),
    .lookup_hit         (lookup_hit),
    .lookup_way         (lookup_way),
    .lookup_mesi        (lookup_mesi),
    .snoop_result       (snoop_result),
    .snoop_result_valid (snoop_result_valid),
    .l2_l1_msg          (l2_l1_msg),
    .l2_l1_valid        (l2_l1_valid),
    .l2_l1_ack          (l2_l1_ack),
    .wb_valid           (wb_valid),
    .wb_addr            (wb_addr),
    .wb_ack             (wb_ack),
    .upd_valid          (upd_valid),
    .upd_index          (upd_index),
    .upd_way            (upd_way),
`ifdef SNOOP_STATS_EN
    .snoop_cnt          (snoop_cnt),
    .hitm_cnt           (hitm_cnt),
`endif
    .upd_mesi           (upd_mesi)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [2:0] op;
    bit         hit;
    logic [1:0] mesi;
    logic [1:0] res;
    bit         get;
    bit         wb;
    bit         inv;
    bit         upd;
    logic [1:0] nxt;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [31:0] addr;
    logic [2:0]  way;
    int          ack_d;
    int          l1_d;
    int          wb_d;
  } tvec_t;

  tvec_t tv[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input bit hit, input logic [1:0] mesi,
                              input logic [1:0] res, input bit get, input bit wb,
                              input bit inv, input bit upd, input logic [1:0] nxt);
    vec_t v;
    v.op = op; v.hit = hit; v.mesi = mesi; v.res = res;
    v.get = get; v.wb = wb; v.inv = inv; v.upd = upd; v.nxt = nxt;
    return v;
  endfunction

  // Protocol rules: a dirty line is pulled from L1 and written back on any
  // snoop that reads it; ownership requests kill the line; a plain read
  // demotes to Shared; only a Shared line honours INVALIDATE.
  function automatic vec_t model(input logic [2:0] op, input bit hit, input logic [1:0] mesi);
    vec_t v;
    int   eff;
    bit   reads;
    eff   = hit ? int'(mesi) : 0;
    reads = (op == 3'd1) || (op == 3'd4);
    v.op = op; v.hit = hit; v.mesi = mesi;
    v.res = !reads ? 2'd0 : (eff == 3) ? 2'd2 : (eff != 0) ? 2'd1 : 2'd0;
    v.get = reads && (eff == 3);
    v.wb  = v.get;
    v.inv = ((op == 3'd4) && (eff != 0)) || ((op == 3'd3) && (eff == 1));
    if (v.inv)                         v.nxt = 2'd0;
    else if ((op == 3'd1) && eff >= 2) v.nxt = 2'd1;
    else                               v.nxt = 2'(eff);
    v.upd = (int'(v.nxt) != eff);
    return v;
  endfunction

  task automatic clear_inputs();
    lookup_ack = 0; lookup_hit = 0; lookup_way = '0; lookup_mesi = '0;
    l2_l1_ack = 0; wb_ack = 0;
  endtask

  // Drive one snoop to completion, acting as tag array, L1 and bus.
  task automatic run_txn(input vec_t v, input logic [31:0] addr, input logic [2:0] way,
                         input int ack_d, input int l1_d, input int wb_d, input bit abort_wb);
    int          cyc, lk, l1h, wbh, nres, nupd, res_cyc, idle_cyc, exp_idle, post_upd;
    bit          done, stable_ok, idx_ok, wb_ok;
    logic [1:0]  res_v, upd_m;
    logic [2:0]  held, upd_w;
    logic [14:0] upd_i, ei;
    logic [10:0] et;
    logic [11:0] asig, esig;
    ei = 15'((addr >> 6) & 32'h7fff);
    et = 11'(addr >> 21);
    lk = 0; l1h = 0; wbh = 0; nres = 0; nupd = 0; res_cyc = -1; idle_cyc = -1;
    done = 0; stable_ok = 1; idx_ok = 1; wb_ok = 1; res_v = '0; held = '0;
    upd_m = '0; upd_w = '0; upd_i = '0; asig = '0; esig = '0;
    if (v.get) esig = {esig[7:0], 4'd1};
    if (v.wb)  esig = {esig[7:0], 4'd2};
    if (v.inv) esig = {esig[7:0], 4'd3};

    chk("ready_before_accept", snoop_ready, 1);
    snoop_valid = 1; snoop_op = v.op; snoop_addr = addr;
    @(posedge clk); @(negedge clk);
    snoop_valid = 0; snoop_op = '0; snoop_addr = '0;
    cyc = 1;
    while (!done && cyc < 300) begin
      clear_inputs();
      if (snoop_ready) begin
        idle_cyc = cyc;
        done = 1;
      end else begin
        if (lookup_req) begin
          if (lookup_index != ei || lookup_tag != et) idx_ok = 0;
          if (lk >= ack_d) begin
            lookup_ack = 1; lookup_hit = v.hit; lookup_way = way; lookup_mesi = v.mesi;
          end
          lk++;
        end
        if (snoop_result_valid) begin
          nres++; res_v = snoop_result; res_cyc = cyc;
        end
        if (l2_l1_valid) begin
          if (l1h == 0) held = l2_l1_msg;
          else if (l2_l1_msg != held) stable_ok = 0;
          if (l1h >= l1_d) begin
            l2_l1_ack = 1;
            asig = {asig[7:0], (held == 3'd1) ? 4'd1 : (held == 3'd3) ? 4'd3 : 4'd7};
            l1h = 0;
          end else l1h++;
        end
        if (wb_valid) begin
          if (wb_addr != (addr & 32'hffff_ffc0)) wb_ok = 0;
          if (abort_wb) begin
            #2 rst = 1;
            #1;
            chk("rst_wb_valid", wb_valid, 0);
            chk("rst_ready", snoop_ready, 1);
            chk("rst_upd_valid", upd_valid, 0);
            chk("rst_l1_valid", l2_l1_valid, 0);
            chk("rst_result_valid", snoop_result_valid, 0);
            chk("rst_wb_addr", wb_addr, 0);
            @(posedge clk); @(negedge clk);
            rst = 0;
            post_upd = 0;
            for (int k = 0; k < 5; k++) begin
              if (upd_valid || !snoop_ready) post_upd++;
              @(posedge clk); @(negedge clk);
            end
            chk("rst_no_update_after", post_upd, 0);
            chk("abort_wb_addr_before_rst", wb_ok, 1);
            return;
          end
          if (wbh >= wb_d) begin
            wb_ack = 1; asig = {asig[7:0], 4'd2}; wbh = 0;
          end else wbh++;
        end
        if (upd_valid) begin
          nupd++; upd_m = upd_mesi; upd_w = upd_way; upd_i = upd_index;
        end
        @(posedge clk); @(negedge clk);
        cyc++;
      end
    end
    clear_inputs();

    exp_idle = 3 + ack_d + (v.get ? l1_d + 1 : 0) + (v.wb ? wb_d + 1 : 0)
                         + (v.inv ? l1_d + 1 : 0) + (v.upd ? 1 : 0);
    chk("reached_idle", done, 1);
    chk("idle_cycle", idle_cyc, exp_idle);
    chk("lookup_index_tag", idx_ok, 1);
    chk("result_strobes", nres, 1);
    chk("result_value", res_v, v.res);
    chk("result_latency", res_cyc, 2 + ack_d);
    chk("msg_sequence", asig, esig);
    chk("msg_stable", stable_ok, 1);
    chk("wb_addr", wb_ok, 1);
    chk("upd_strobes", nupd, v.upd ? 1 : 0);
    if (v.upd) begin
      chk("upd_mesi", upd_m, v.nxt);
      chk("upd_way", upd_w, way);
      chk("upd_index", upd_i, ei);
    end
  endtask

  initial begin
    rst = 1; snoop_valid = 0; snoop_op = '0; snoop_addr = '0;
    clear_inputs();
    repeat (2) @(negedge clk);
    chk("reset_ready", snoop_ready, 1);
    chk("reset_lookup_req", lookup_req, 0);
    chk("reset_result_valid", snoop_result_valid, 0);
    chk("reset_result", snoop_result, 0);
    chk("reset_l1_valid", l2_l1_valid, 0);
    chk("reset_l1_msg", l2_l1_msg, 0);
    chk("reset_wb_valid", wb_valid, 0);
    chk("reset_wb_addr", wb_addr, 0);
    chk("reset_upd_valid", upd_valid, 0);
    chk("reset_upd_mesi", upd_mesi, 0);
    rst = 0;
    @(negedge clk);

`ifdef SNOOP_STATS_EN
    chk("stats_reset_snoop", snoop_cnt, 0);
    chk("stats_reset_hitm", hitm_cnt, 0);
    run_txn(mk(OP_READ,  1, MESI_M, 2, 1, 1, 0, 1, MESI_S), 32'h0000_1000, 3'd1, 0, 0, 0, 0);
    run_txn(mk(OP_READ,  0, MESI_M, 0, 0, 0, 0, 0, MESI_I), 32'h0000_2000, 3'd0, 0, 0, 0, 0);
    run_txn(mk(OP_WRITE, 1, MESI_E, 0, 0, 0, 0, 0, MESI_E), 32'h0000_3000, 3'd2, 0, 0, 0, 0);
    run_txn(mk(OP_RWIM,  1, MESI_S, 1, 0, 0, 1, 1, MESI_I), 32'h0000_4000, 3'd4, 0, 0, 0, 0);
    chk("stats_snoop_cnt", snoop_cnt, 4);
    chk("stats_hitm_cnt", hitm_cnt, 1);
`endif

    // op, hit, mesi | result, get, wb, inv, upd, next
    tv[0]  = '{mk(OP_READ,       1, MESI_M, 2, 1, 1, 0, 1, MESI_S), 32'h0001_2345, 3'd5, 0, 0, 0};
    tv[1]  = '{mk(OP_RWIM,       1, MESI_S, 1, 0, 0, 1, 1, MESI_I), 32'h00AB_CDEF, 3'd2, 0, 0, 0};
    tv[2]  = '{mk(OP_READ,       0, MESI_M, 0, 0, 0, 0, 0, MESI_I), 32'hDEAD_BEEF, 3'd0, 0, 0, 0};
    tv[3]  = '{mk(OP_INVALIDATE, 1, MESI_E, 0, 0, 0, 0, 0, MESI_E), 32'h1234_5678, 3'd1, 0, 0, 0};
    tv[4]  = '{mk(OP_WRITE,      1, MESI_M, 0, 0, 0, 0, 0, MESI_M), 32'h8765_4321, 3'd7, 0, 0, 0};
    tv[5]  = '{mk(OP_READ,       1, MESI_E, 1, 0, 0, 0, 1, MESI_S), 32'hFFFF_FFFF, 3'd6, 1, 0, 0};
    tv[6]  = '{mk(OP_READ,       1, MESI_S, 1, 0, 0, 0, 0, MESI_S), 32'h0000_0000, 3'd3, 0, 0, 0};
    tv[7]  = '{mk(OP_RWIM,       1, MESI_M, 2, 1, 1, 1, 1, MESI_I), 32'h4000_0040, 3'd4, 2, 1, 2};
    tv[8]  = '{mk(OP_RWIM,       1, MESI_E, 1, 0, 0, 1, 1, MESI_I), 32'h7FFF_FFC0, 3'd0, 0, 3, 0};
    tv[9]  = '{mk(OP_INVALIDATE, 1, MESI_S, 0, 0, 0, 1, 1, MESI_I), 32'h0F0F_0F0F, 3'd7, 0, 0, 0};
    tv[10] = '{mk(OP_READ,       1, MESI_M, 2, 1, 1, 0, 1, MESI_S), 32'h0001_2345, 3'd5, 0, 10, 1};
    tv[11] = '{mk(OP_READ,       1, MESI_I, 0, 0, 0, 0, 0, MESI_I), 32'h5555_AAAA, 3'd2, 0, 0, 0};
    tv[12] = '{mk(OP_RWIM,       0, MESI_S, 0, 0, 0, 0, 0, MESI_I), 32'hAAAA_5555, 3'd1, 3, 0, 0};

    for (int i = 0; i < 13; i++)
      run_txn(tv[i].v, tv[i].addr, tv[i].way, tv[i].ack_d, tv[i].l1_d, tv[i].wb_d, 0);

    for (int i = 0; i < 60; i++) begin
      logic [2:0]  op;
      bit          hit;
      logic [1:0]  st;
      op  = 3'($urandom_range(1, 4));
      hit = 1'($urandom_range(0, 1));
      st  = 2'($urandom_range(0, 3));
      run_txn(model(op, hit, st), $urandom, 3'($urandom_range(0, 7)),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end

    // Reset while the writeback is pending: must drop to IDLE with no update
    run_txn(mk(OP_READ, 1, MESI_M, 2, 1, 1, 0, 1, MESI_S), 32'h0002_4680, 3'd3, 0, 0, 5, 1);
    // Responder must be fully usable after the abort
    run_txn(tv[0].v, tv[0].addr, tv[0].way, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_snoop_responder
`default_nettype wire
